// File: rtl/cp0_exception_ctrl.sv
// Coprocessor-0 exception controller at the MEM stage: Status/Cause/EPC/BadVAddr
// registers, exception/interrupt arbitration, ERET and MTC0/MFC0. Timer under CP0_TIMER_EN.
module cp0_exception_ctrl #(
    parameter logic [31:0] RESET_STATUS = 32'h0000_FF00,
    parameter int unsigned HW_INT_NUM   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_MEM_valid,
    input  logic [31:0]           i_MEM_pc,
    input  logic                  i_MEM_in_delay_slot,
    input  logic                  i_MEM_exc_valid,
    input  logic [4:0]            i_MEM_exc_cause,
    input  logic [31:0]           i_MEM_bad_vaddr,
    input  logic                  i_MEM_is_eret,
    input  logic                  i_MEM_cp0_we,
    input  logic [4:0]            i_MEM_cp0_addr,
    input  logic [31:0]           i_MEM_cp0_wdata,
    input  logic [HW_INT_NUM-1:0] i_hw_int,
    output logic                  o_answer_exc,
    output logic [4:0]            o_MEM_exception_cause,
    output logic [31:0]           o_MEM_epc_value,
    output logic [31:0]           o_cp0_rdata,
    output logic                  o_flush
);

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [1:0]  r_ip_sw;
    logic [5:0]  r_ip_hw;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;

    logic        w_timer_int;
    logic [31:0] w_count_rd;
    logic [31:0] w_compare_rd;
    logic [7:0]  w_ip;
    logic        w_int_pend;
    logic        w_take_exc;
    logic        w_take_int;
    logic        w_answer;
    logic [4:0]  w_cause_sel;
    logic        w_eret;
    logic        w_mtc0;
    logic [31:0] w_status;
    logic [31:0] w_cause;

    // Timer interrupt appears on IP[15] alongside the highest hardware line
    assign w_ip       = {r_ip_hw[5] | w_timer_int, r_ip_hw[4:0], r_ip_sw};
    assign w_int_pend = r_ie & ~r_exl & (|(w_ip & r_im));

    assign w_take_exc  = i_MEM_valid & i_MEM_exc_valid;
    assign w_take_int  = i_MEM_valid & w_int_pend & ~i_MEM_exc_valid;
    assign w_answer    = w_take_exc | w_take_int;
    assign w_cause_sel = w_take_exc ? i_MEM_exc_cause : EXC_INT;
    assign w_eret      = i_MEM_valid & i_MEM_is_eret & ~w_answer;
    assign w_mtc0      = i_MEM_valid & i_MEM_cp0_we & ~w_answer;

    assign w_status = {16'h0000, r_im, 6'b000000, r_exl, r_ie};
    assign w_cause  = {r_bd, 15'h0000, w_ip, 1'b0, r_exc_code, 2'b00};

    // Event outputs are forced low while reset is held
    assign o_answer_exc          = ~reset & w_answer;
    assign o_MEM_exception_cause = (~reset & w_answer) ? w_cause_sel : 5'd0;
    assign o_flush               = ~reset & (w_answer | w_eret);
    assign o_MEM_epc_value       = reset ? 32'h0000_0000 : r_epc;

    always_comb begin
        o_cp0_rdata = 32'h0000_0000;
        case (i_MEM_cp0_addr)
            REG_BADVADDR: o_cp0_rdata = r_badvaddr;
            REG_COUNT:    o_cp0_rdata = w_count_rd;
            REG_COMPARE:  o_cp0_rdata = w_compare_rd;
            REG_STATUS:   o_cp0_rdata = w_status;
            REG_CAUSE:    o_cp0_rdata = w_cause;
            REG_EPC:      o_cp0_rdata = r_epc;
            default:      o_cp0_rdata = 32'h0000_0000;
        endcase
    end

    // Status, Cause, EPC and BadVAddr update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_im       <= RESET_STATUS[15:8];
            r_exl      <= RESET_STATUS[1];
            r_ie       <= RESET_STATUS[0];
            r_bd       <= 1'b0;
            r_ip_sw    <= 2'b00;
            r_ip_hw    <= 6'b000000;
            r_exc_code <= 5'd0;
            r_epc      <= 32'h0000_0000;
            r_badvaddr <= 32'h0000_0000;
        end else begin
            r_ip_hw <= 6'(i_hw_int);
            if (w_answer) begin
                r_exl      <= 1'b1;
                r_exc_code <= w_cause_sel;
                if (!r_exl) begin
                    r_epc <= i_MEM_in_delay_slot ? (i_MEM_pc - 32'd4) : i_MEM_pc;
                    r_bd  <= i_MEM_in_delay_slot;
                end
                if (w_take_exc && (i_MEM_exc_cause == EXC_ADEL || i_MEM_exc_cause == EXC_ADES)) begin
                    r_badvaddr <= i_MEM_bad_vaddr;
                end
            end else begin
                if (w_eret) begin
                    r_exl <= 1'b0;
                end
                if (w_mtc0) begin
                    case (i_MEM_cp0_addr)
                        REG_STATUS: begin
                            r_im  <= i_MEM_cp0_wdata[15:8];
                            r_exl <= i_MEM_cp0_wdata[1];
                            r_ie  <= i_MEM_cp0_wdata[0];
                        end
                        REG_CAUSE: r_ip_sw <= i_MEM_cp0_wdata[9:8];
                        REG_EPC:   r_epc   <= i_MEM_cp0_wdata;
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_tick;
    logic        r_timer_int;
    logic [31:0] w_count_inc;
    logic        w_wr_count;
    logic        w_wr_compare;

    assign w_count_inc  = r_count + 32'd1;
    assign w_wr_count   = w_mtc0 & (i_MEM_cp0_addr == REG_COUNT);
    assign w_wr_compare = w_mtc0 & (i_MEM_cp0_addr == REG_COMPARE);

    // Count advances every second cycle; a match after an increment sets the sticky flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= 32'h0000_0000;
            r_compare   <= 32'h0000_0000;
            r_tick      <= 1'b0;
            r_timer_int <= 1'b0;
        end else begin
            r_tick <= ~r_tick;
            if (w_wr_count) begin
                r_count <= i_MEM_cp0_wdata;
            end else if (r_tick) begin
                r_count <= w_count_inc;
            end
            if (w_wr_compare) begin
                r_compare   <= i_MEM_cp0_wdata;
                r_timer_int <= 1'b0;
            end else if (r_tick && !w_wr_count && (w_count_inc == r_compare)) begin
                r_timer_int <= 1'b1;
            end
        end
    end

    assign w_timer_int  = r_timer_int;
    assign w_count_rd   = r_count;
    assign w_compare_rd = r_compare;
`else
    assign w_timer_int  = 1'b0;
    assign w_count_rd   = 32'h0000_0000;
    assign w_compare_rd = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Directed self-checking bench for cp0_exception_ctrl.
module tb_cp0_exception_ctrl;

    logic        clk;
    logic        reset;
    logic        i_MEM_valid;
    logic [31:0] i_MEM_pc;
    logic        i_MEM_in_delay_slot;
    logic        i_MEM_exc_valid;
    logic [4:0]  i_MEM_exc_cause;
    logic [31:0] i_MEM_bad_vaddr;
    logic        i_MEM_is_eret;
    logic        i_MEM_cp0_we;
    logic [4:0]  i_MEM_cp0_addr;
    logic [31:0] i_MEM_cp0_wdata;
    logic [5:0]  i_hw_int;
    logic        o_answer_exc;
    logic [4:0]  o_MEM_exception_cause;
    logic [31:0] o_MEM_epc_value;
    logic [31:0] o_cp0_rdata;
    logic        o_flush;

    int total = 0;
    int bad   = 0;

    cp0_exception_ctrl dut (
        .clk                   (clk),
        .reset                 (reset),
        .i_MEM_valid           (i_MEM_valid),
        .i_MEM_pc              (i_MEM_pc),
        .i_MEM_in_delay_slot   (i_MEM_in_delay_slot),
        .i_MEM_exc_valid       (i_MEM_exc_valid),
        .i_MEM_exc_cause       (i_MEM_exc_cause),
        .i_MEM_bad_vaddr       (i_MEM_bad_vaddr),
        .i_MEM_is_eret         (i_MEM_is_eret),
        .i_MEM_cp0_we          (i_MEM_cp0_we),
        .i_MEM_cp0_addr        (i_MEM_cp0_addr),
        .i_MEM_cp0_wdata       (i_MEM_cp0_wdata),
        .i_hw_int              (i_hw_int),
        .o_answer_exc          (o_answer_exc),
        .o_MEM_exception_cause (o_MEM_exception_cause),
        .o_MEM_epc_value       (o_MEM_epc_value),
        .o_cp0_rdata           (o_cp0_rdata),
        .o_flush               (o_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_MEM_valid         = 1'b0;
        i_MEM_pc            = 32'h0;
        i_MEM_in_delay_slot = 1'b0;
        i_MEM_exc_valid     = 1'b0;
        i_MEM_exc_cause     = 5'd0;
        i_MEM_bad_vaddr     = 32'h0;
        i_MEM_is_eret       = 1'b0;
        i_MEM_cp0_we        = 1'b0;
        i_MEM_cp0_addr      = 5'd0;
        i_MEM_cp0_wdata     = 32'h0;
    endtask

    task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp);
        i_MEM_cp0_addr = addr;
        #1;
        chk(tag, o_cp0_rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        idle();
        i_MEM_valid     = 1'b1;
        i_MEM_cp0_we    = 1'b1;
        i_MEM_cp0_addr  = addr;
        i_MEM_cp0_wdata = data;
        tick();
        idle();
    endtask

    initial begin
        bit found;
        idle();
        i_hw_int = 6'd0;
        reset    = 1'b1;
        // Event inputs during reset must not produce an answer
        i_MEM_valid     = 1'b1;
        i_MEM_exc_valid = 1'b1;
        i_MEM_exc_cause = 5'd12;
        tick();
        #1;
        chk("reset_answer", 32'(o_answer_exc), 32'd0);
        chk("reset_flush", 32'(o_flush), 32'd0);
        tick();
        reset = 1'b0;
        idle();
        rd(5'd12, "reset_status", 32'h0000_FF00);
        rd(5'd14, "reset_epc", 32'h0);
        chk("idle_answer", 32'(o_answer_exc), 32'd0);

        // Overflow in a delay slot
        i_MEM_valid         = 1'b1;
        i_MEM_exc_valid     = 1'b1;
        i_MEM_exc_cause     = 5'd12;
        i_MEM_pc            = 32'h0000_1004;
        i_MEM_in_delay_slot = 1'b1;
        #1;
        chk("ov_answer", 32'(o_answer_exc), 32'd1);
        chk("ov_cause", 32'(o_MEM_exception_cause), 32'd12);
        chk("ov_flush", 32'(o_flush), 32'd1);
        tick();
        idle();
        rd(5'd14, "ov_epc", 32'h0000_1000);
        rd(5'd13, "ov_cause_reg", 32'h8000_0030);
        rd(5'd12, "ov_status", 32'h0000_FF02);

        // Hardware interrupt 0 enabled via IM2 and IE
        mtc0(5'd12, 32'h0000_0401);
        rd(5'd12, "st_401", 32'h0000_0401);
        i_hw_int = 6'd1;
        tick();
        #1;
        chk("int_bubble", 32'(o_answer_exc), 32'd0);
        rd(5'd13, "int_ip", 32'h8000_0430);
        tick();
        i_MEM_valid = 1'b1;
        i_MEM_pc    = 32'h0000_1800;
        #1;
        chk("int_answer", 32'(o_answer_exc), 32'd1);
        chk("int_cause", 32'(o_MEM_exception_cause), 32'd0);
        tick();
        i_MEM_pc = 32'h0000_1804;
        #1;
        chk("int_exl_masked", 32'(o_answer_exc), 32'd0);
        rd(5'd14, "int_epc", 32'h0000_1800);
        rd(5'd13, "int_cause_reg", 32'h0000_0400);

        // MTC0 EPC then ERET sees the new EPC immediately
        i_hw_int = 6'd0;
        mtc0(5'd14, 32'h0000_2000);
        i_MEM_valid   = 1'b1;
        i_MEM_is_eret = 1'b1;
        #1;
        chk("eret_epc", o_MEM_epc_value, 32'h0000_2000);
        chk("eret_flush", 32'(o_flush), 32'd1);
        chk("eret_answer", 32'(o_answer_exc), 32'd0);
        tick();
        idle();
        rd(5'd12, "eret_status", 32'h0000_0401);

        // Address error together with an MTC0 Status in the same instruction
        i_MEM_valid     = 1'b1;
        i_MEM_exc_valid = 1'b1;
        i_MEM_exc_cause = 5'd4;
        i_MEM_bad_vaddr = 32'h0000_0003;
        i_MEM_pc        = 32'h0000_3000;
        i_MEM_cp0_we    = 1'b1;
        i_MEM_cp0_addr  = 5'd12;
        i_MEM_cp0_wdata = 32'hFFFF_FF00;
        #1;
        chk("adel_answer", 32'(o_answer_exc), 32'd1);
        chk("adel_cause", 32'(o_MEM_exception_cause), 32'd4);
        tick();
        idle();
        rd(5'd8, "adel_badvaddr", 32'h0000_0003);
        rd(5'd13, "adel_cause_reg", 32'h0000_0010);
        rd(5'd12, "adel_status", 32'h0000_0403);
        rd(5'd14, "adel_epc", 32'h0000_3000);

        // Nested exception with EXL=1 keeps EPC and BD
        i_MEM_valid         = 1'b1;
        i_MEM_exc_valid     = 1'b1;
        i_MEM_exc_cause     = 5'd8;
        i_MEM_pc            = 32'h0000_4004;
        i_MEM_in_delay_slot = 1'b1;
        tick();
        idle();
        rd(5'd14, "nest_epc", 32'h0000_3000);
        rd(5'd13, "nest_cause_reg", 32'h0000_0020);

        // Unmapped register ignores writes
        mtc0(5'd20, 32'h1234_5678);
        rd(5'd20, "unmapped", 32'h0);

`ifdef CP0_TIMER_EN
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd5);
        mtc0(5'd12, 32'h0000_8001);
        found = 1'b0;
        i_MEM_valid = 1'b1;
        for (int i = 0; i < 30 && !found; i++) begin
            #1;
            if (o_answer_exc) found = 1'b1;
            else tick();
        end
        chk("timer_answered", 32'(found), 32'd1);
        chk("timer_cause", 32'(o_MEM_exception_cause), 32'd0);
        tick();
        idle();
        i_MEM_cp0_addr = 5'd13;
        #1;
        chk("timer_ip15", 32'(o_cp0_rdata[15]), 32'd1);
        mtc0(5'd11, 32'h0000_0100);
        i_MEM_cp0_addr = 5'd13;
        #1;
        chk("timer_ip15_clr", 32'(o_cp0_rdata[15]), 32'd0);
`else
        found = 1'b0;
        mtc0(5'd9, 32'h0000_0055);
        mtc0(5'd11, 32'h0000_0066);
        rd(5'd9, "count_off", 32'h0);
        rd(5'd11, "compare_off", 32'h0);
        chk("timer_off_found", 32'(found), 32'd0);
`endif

        // Reset asserted during an exception cycle
        i_MEM_valid     = 1'b1;
        i_MEM_exc_valid = 1'b1;
        i_MEM_exc_cause = 5'd4;
        i_MEM_bad_vaddr = 32'hDEAD_BEEF;
        i_MEM_pc        = 32'h0000_5000;
        reset           = 1'b1;
        #1;
        chk("rst_mid_answer", 32'(o_answer_exc), 32'd0);
        tick();
        reset = 1'b0;
        idle();
        rd(5'd12, "rst_mid_status", 32'h0000_FF00);
        rd(5'd14, "rst_mid_epc", 32'h0);
        rd(5'd8, "rst_mid_badvaddr", 32'h0);
        rd(5'd13, "rst_mid_cause", 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
